// File: rtl/sar_adc_reader.sv
// sar_adc_reader: starts conversions on a bank of serial SAR ADCs, handshakes on Busy and reads all channels out in parallel
module sar_adc_reader #(
  parameter int NCH          = 2,
  parameter int BITS         = 18,
  parameter int SCLK_DIV     = 1,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Sync,
  output logic                Reset,
  output logic                nCnvSt,
  input  logic [NCH-1:0]      Busy,
  output logic                SClk,
  input  logic [NCH-1:0]      Data,
  output logic [NCH*BITS-1:0] DataOut,
  output logic                Valid,
  output logic                Overrun,
  output logic                Timeout
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int BW = $clog2(BITS + 1);
  localparam int DW = $clog2(SCLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAITB, SHI, SLO} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                sync_q, sync_d;
  logic [NCH-1:0]            tbusy_q, tbusy_d;
  logic                      ncnvst_q, ncnvst_d;
  logic                      sclk_q, sclk_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      timeout_q, timeout_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [DW-1:0]             div_q, div_d;
  logic [NCH-1:0][BITS-1:0]  sh_q, sh_d;
  logic [NCH*BITS-1:0]       dout_q, dout_d;
  logic                      sync_edge, all_busy, none_busy, tmo_hit, div_end, last_bit;

  // sync_q[0] may be metastable; the edge is taken between the two settled stages
  assign sync_edge = sync_q[1] & ~sync_q[2];
  assign all_busy  = &tbusy_q;
  assign none_busy = ~|tbusy_q;
  assign tmo_hit   = tmo_q == TW'(BUSY_TIMEOUT - 1);
  assign div_end   = div_q == DW'(SCLK_DIV - 1);
  assign last_bit  = bit_q == BW'(BITS);

  // state register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: handshake, busy waits with timeout, then BITS high/low SClk phases
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sync_edge ? CONV : IDLE;
      CONV:    state_d = all_busy ? WAITB : tmo_hit ? IDLE : CONV;
      WAITB:   state_d = none_busy ? SHI : tmo_hit ? IDLE : WAITB;
      SHI:     state_d = div_end ? SLO : SHI;
      SLO:     state_d = !div_end ? SLO : last_bit ? IDLE : SHI;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath: counters restart on every state change, data shifts on the SClk falling edge
  always_comb begin
    sync_d    = {sync_q[1:0], Sync};
    tbusy_d   = Busy;
    ncnvst_d  = state_d != CONV;
    sclk_d    = state_d == SHI;
    tmo_d     = (state_d == state_q && (state_q == CONV || state_q == WAITB)) ? tmo_q + TW'(1) : '0;
    div_d     = (state_d == state_q && (state_q == SHI || state_q == SLO)) ? div_q + DW'(1) : '0;
    bit_d     = state_q == WAITB ? '0 : (state_q == SHI && div_end) ? bit_q + BW'(1) : bit_q;
    sh_d      = sh_q;
    for (int i = 0; i < NCH; i++)
      if (state_q == SHI && div_end) sh_d[i] = {sh_q[i][BITS-2:0], Data[i]};
    valid_d   = state_q == SLO && div_end && last_bit;
    dout_d    = dout_q;
    for (int i = 0; i < NCH; i++)
      if (valid_d) dout_d[(NCH-i)*BITS-1 -: BITS] = sh_q[i];
    overrun_d = sync_edge && state_q != IDLE;
    timeout_d = (state_q == CONV || state_q == WAITB) && state_d == IDLE;
  end

  // datapath and output registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync_q    <= '0;
      tbusy_q   <= '0;
      ncnvst_q  <= 1'b1;
      sclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      tmo_q     <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      tbusy_q   <= tbusy_d;
      ncnvst_q  <= ncnvst_d;
      sclk_q    <= sclk_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
    end
  end

  assign Reset   = ~nReset;
  assign nCnvSt  = ncnvst_q;
  assign SClk    = sclk_q;
  assign DataOut = dout_q;
  assign Valid   = valid_q;
  assign Overrun = overrun_q;
  assign Timeout = timeout_q;
endmodule
